// File: rtl/seg7_pkg.sv
// Shared BCD digit width, seven-segment patterns (gfedcba, active-high)
// and the single-digit BCD up/down step used by the counter chains.
package seg7_pkg;

   localparam int BCD_W = 4;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef struct packed {
      logic             carry;
      logic [BCD_W-1:0] digit;
   } bcd_step_t;

   // carry doubles as borrow when counting down
   function automatic bcd_step_t bcd_next(input logic [BCD_W-1:0] d, input logic up);
      bcd_step_t r;
      if (up) begin
         r.carry = (d >= 4'd9);
         r.digit = r.carry ? 4'd0 : d + 4'd1;
      end else begin
         r.carry = (d == 4'd0);
         r.digit = r.carry ? 4'd9 : d - 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7.sv
// BCD to seven-segment decoder; codes above 9 decode to blank.
module seg7
   import seg7_pkg::*;
(
   input  logic [BCD_W-1:0] bcd_i,
   output logic [6:0]       seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_multi_counter.sv
// N-digit BCD up/down counter with prescaler and multiplexed 7-seg scan.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_multi_counter
   import seg7_pkg::*;
#(
   parameter int MAX_COUNT  = 1000,
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          run_i,
   input  logic                          up_i,
   input  logic                          clr_i,
   input  logic                          load_i,
   input  logic [BCD_W*NUM_DIGITS-1:0]   load_val_i,
   output logic [BCD_W*NUM_DIGITS-1:0]   count_o,
   output logic [6:0]                    seg_o,
   output logic [NUM_DIGITS-1:0]         dig_en_o,
   output logic                          tick_o,
   output logic                          wrap_o
);

   localparam int PW = $clog2(MAX_COUNT + 1);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [PW-1:0]                        pre_q, pre_d;
   logic [NUM_DIGITS-1:0][BCD_W-1:0]     digit_q, digit_d;
   logic                                 tick_q, tick_d, wrap_q, wrap_d;
   logic [SW-1:0]                        scan_cnt_q, scan_cnt_d;
   logic [IW-1:0]                        scan_idx_q, scan_idx_d;
   logic [NUM_DIGITS-1:0]                dig_en_q, dig_en_d;
   logic [6:0]                           seg_q, seg_d, seg_dec;
   logic [BCD_W-1:0]                     scan_digit, nib;
   logic                                 carry;
   bcd_step_t                            step;

   always_comb begin
      digit_d = digit_q;
      pre_d   = pre_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      carry   = 1'b1;
      step    = '0;
      nib     = '0;
      if (clr_i) begin
         digit_d = '0;
         pre_d   = '0;
      end else if (load_i) begin
         pre_d = '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            nib        = load_val_i[i*BCD_W +: BCD_W];
            digit_d[i] = (nib > 4'd9) ? 4'd9 : nib;
         end
      end else if (run_i) begin
         if (pre_q == PW'(MAX_COUNT)) begin
            pre_d  = '0;
            tick_d = 1'b1;
            // ripple: a digit only steps while every lower digit carried
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (carry) begin
                  step       = bcd_next(digit_q[i], up_i);
                  digit_d[i] = step.digit;
                  carry      = step.carry;
               end
            end
            wrap_d = carry;
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end
   end

   always_comb begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      scan_idx_d = scan_idx_q;
      if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
         scan_cnt_d = '0;
         scan_idx_d = (scan_idx_q == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
      end
      dig_en_d = NUM_DIGITS'(1) << scan_idx_q;
   end

   assign scan_digit = digit_q[scan_idx_q];

   seg7 u_seg7 (
      .bcd_i (scan_digit),
      .seg_o (seg_dec)
   );

`ifdef SEG7_LZB_EN
   logic [NUM_DIGITS-1:0] lz;

   // lz[i]: digit i and every digit above it are zero
   always_comb begin
      lz = '0;
      for (int i = 0; i < NUM_DIGITS; i++) lz[i] = ((digit_q >> (BCD_W*i)) == '0);
   end

   assign seg_d = ((scan_idx_q != '0) && lz[scan_idx_q]) ? SEG_BLANK : seg_dec;
`else
   assign seg_d = seg_dec;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q      <= '0;
         digit_q    <= '0;
         tick_q     <= 1'b0;
         wrap_q     <= 1'b0;
         scan_cnt_q <= '0;
         scan_idx_q <= '0;
         dig_en_q   <= '0;
         seg_q      <= '0;
      end else begin
         pre_q      <= pre_d;
         digit_q    <= digit_d;
         tick_q     <= tick_d;
         wrap_q     <= wrap_d;
         scan_cnt_q <= scan_cnt_d;
         scan_idx_q <= scan_idx_d;
         dig_en_q   <= dig_en_d;
         seg_q      <= seg_d;
      end
   end

   assign count_o  = digit_q;
   assign seg_o    = seg_q;
   assign dig_en_o = dig_en_q;
   assign tick_o   = tick_q;
   assign wrap_o   = wrap_q;

endmodule

// File: doc/seg7_multi_counter.md
Name: seg7_multi_counter

Overview:
- Parametrised successor to the single-digit seconds counter.
- An N-digit BCD up/down counter advanced by a prescaler tick, with synchronous clear, synchronous load and run/hold control.
- Drives a time-multiplexed common seven-segment display: one shared segment bus plus one-hot digit enables.
- Sits between the user I/O pins and the existing `seg7` decoder.

Parameters:
- MAX_COUNT, 1000: prescaler terminal value; tick period is MAX_COUNT+1 clocks; legal range ≥ 1.
- NUM_DIGITS, 4: number of BCD digits; legal range 1..8.
- SCAN_DIV, 16: clocks each digit stays selected during display multiplexing; legal range ≥ 1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- run_i  input  1  1 = prescaler runs and counting is enabled; 0 = hold.
- up_i  input  1  1 = count up, 0 = count down; sampled on each tick.
- clr_i  input  1  synchronous clear of digits and prescaler.
- load_i  input  1  synchronous load of load_val_i.
- load_val_i  input  4*NUM_DIGITS  BCD load value; digit 0 is in bits [3:0].
- count_o  output  4*NUM_DIGITS  current BCD count, registered.
- seg_o  output  7  segments of the currently scanned digit, active-high, registered.
- dig_en_o  output  NUM_DIGITS  one-hot digit select, registered.
- tick_o  output  1  one-cycle pulse; high in the cycle after a count update.
- wrap_o  output  1  one-cycle pulse, coincident with tick_o, when the count wraps.

Behaviour:
- Reset values (rst_n low, asynchronous): prescaler 0, all digits 0, scan counter 0, scan index 0, count_o 0, seg_o 0, dig_en_o 0, tick_o 0, wrap_o 0.
- Prescaler:
  - Width is $clog2(MAX_COUNT+1).
  - While run_i=1 it increments by 1. At MAX_COUNT it returns to 0 and generates an internal tick.
  - While run_i=0 it holds its value.
- Priority each cycle: clr_i, then load_i, then tick.
  - clr_i: digits = 0, prescaler = 0, no tick_o.
  - load_i: digits = load_val_i, prescaler = 0, no tick_o. Any loaded nibble >9 is stored as 9.
- Tick with up_i=1: digit 0 increments, with decimal carry into higher digits. All-9s becomes all-0s and sets wrap.
- Tick with up_i=0: digit 0 decrements, with decimal borrow. All-0s becomes all-9s and sets wrap.
- tick_o and wrap_o are registered: they assert in the cycle in which count_o first shows the new value, and last exactly one cycle.
- Scan:
  - The scan counter runs 0..SCAN_DIV-1 regardless of run_i.
  - On reaching SCAN_DIV-1 it returns to 0 and the scan index advances. The index wraps from NUM_DIGITS-1 to 0.
  - Every cycle, dig_en_o <= 1<<index and seg_o <= seg7(digit[index]), so there is one cycle of latency from index to outputs.
  - The first clock after reset release gives dig_en_o = 1 with seg_o showing digit 0.
- seg_o reflects the digit value as it stood in the previous cycle; the one-cycle lag after a tick is acceptable.
- A count change never disturbs the scan phase.
- NUM_DIGITS=1: dig_en_o is held at 1 after the first clock.
- A reset asserted mid-tick or mid-scan returns everything to the reset values immediately; no pulse is emitted after release.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- Defined:
  - For a scanned digit i>0 that is 0 with all higher digits also 0, seg_o is forced to 7'b0. dig_en_o is unchanged.
  - Digit 0 is never blanked.
- Undefined: all digits are always decoded. No extra logic is present.

Decomposition:
- Package seg7_pkg holds:
  - the BCD digit width constant (4);
  - the segment-pattern constants for 0..9 and blank;
  - a function returning the BCD next value for up/down with carry out. This function is shared with future timer blocks.
- Sub-module: the existing `seg7` decoder, instantiated once on the scan-muxed digit. The BCD counter chain stays inline.

Test Plan:
- MAX_COUNT=3, NUM_DIGITS=2, run_i=1, up_i=1 from reset → count_o increments every 4 clocks: 00, 01, … 99, 00. wrap_o pulses once, with tick_o, at the 99→00 transition.
- up_i=0 from 00 → the first tick gives 99 with wrap_o=1; the next tick gives 98 with wrap_o=0.
- load_val_i=8'h3F with load_i pulsed → count_o=8'h39. Prescaler restarts, so the next tick comes exactly 4 clocks after the load. clr_i and load_i asserted together → count_o=0.
- run_i=0 for 10 clocks with prescaler at 2 → count_o and the prescaler hold. After run_i returns to 1, the tick arrives after 2 clocks. Scan continues throughout the hold.
- SCAN_DIV=2, NUM_DIGITS=4, count 1234 → dig_en_o sequence 0001,0001,0010,0010,0100,0100,1000,1000 with seg_o showing 4,3,2,1. Asynchronous reset asserted mid-scan → all outputs 0 immediately.
- With SEG7_LZB_EN, count 0007 → seg_o is blank for digits 3..1 and shows '7' for digit 0. Count 0000 → only digit 0 shows '0'.
